// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, each owner keeps it for up to weight[i] cycles.
// Define WRR_LOCK_EN to add the lock input, which freezes the current owner's credit while asserted.
module weighted_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
`ifdef WRR_LOCK_EN
    input  logic                         lock,
`endif
    output logic [NUM_REQ-1:0]           grant,
    output logic                         grant_vld,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [WEIGHT_W-1:0]          credit,
    output logic [NUM_REQ-1:0]           next_mask
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   mask_q, mask_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;
    logic                 vld_q, vld_d;

    logic [NUM_REQ-1:0]   masked;
    logic [ID_W-1:0]      masked_id, any_id, pick_id;
    logic [WEIGHT_W-1:0]  pick_w;
    logic [NUM_REQ-1:0]   pick_mask;
    logic                 pick_vld;
    logic                 lock_hold;
    logic                 hold;

`ifdef WRR_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Winner selection: lowest index above the last owner, else lowest overall.
    always_comb begin
        masked    = req & mask_q;
        masked_id = '0;
        any_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) masked_id = ID_W'(i);
            if (req[i])    any_id    = ID_W'(i);
        end
        pick_vld = |req;
        pick_id  = (|masked) ? masked_id : any_id;

        pick_w    = '0;
        pick_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_id) pick_w = weight[i*WEIGHT_W +: WEIGHT_W];
            pick_mask[i] = (ID_W'(i) > pick_id);
        end
        if (pick_w == '0) pick_w = WEIGHT_W'(1);
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        mask_d   = mask_q;
        id_d     = id_q;
        credit_d = credit_q;
        vld_d    = vld_q;
        hold     = 1'b0;

        unique case (state_q)
            OWN:     hold = req[id_q] && (lock_hold || (credit_q > WEIGHT_W'(1)));
            default: hold = 1'b0;
        endcase

        if (hold) begin
            if (!lock_hold) credit_d = credit_q - WEIGHT_W'(1);
        end else if (pick_vld) begin
            state_d  = OWN;
            grant_d  = NUM_REQ'(1) << pick_id;
            id_d     = pick_id;
            credit_d = pick_w;
            mask_d   = pick_mask;
            vld_d    = 1'b1;
        end else begin
            state_d  = IDLE;
            grant_d  = '0;
            id_d     = '0;
            credit_d = '0;
            vld_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            mask_q   <= '1;
            id_q     <= '0;
            credit_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            mask_q   <= mask_d;
            id_q     <= id_d;
            credit_q <= credit_d;
            vld_q    <= vld_d;
        end
    end

    assign grant     = grant_q;
    assign grant_vld = vld_q;
    assign grant_id  = id_q;
    assign credit    = credit_q;
    assign next_mask = mask_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed + short random bench for weighted_rr_arbiter against a pointer-based round-robin model.
module tb_weighted_rr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] weight;
`ifdef WRR_LOCK_EN
    logic           lock;
`endif
    logic [N-1:0]   grant;
    logic           grant_vld;
    logic [1:0]     grant_id;
    logic [W-1:0]   credit;
    logic [N-1:0]   next_mask;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: owner index (-1 idle), remaining cycles, and priority start pointer.
    int m_owner = -1;
    int m_credit = 0;
    int m_ptr = 0;

    weighted_rr_arbiter #(.NUM_REQ(N), .WEIGHT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .weight    (weight),
`ifdef WRR_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .credit    (credit),
        .next_mask (next_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        int  cand;
        int  w;
        bit  lk;
`ifdef WRR_LOCK_EN
        lk = (lock === 1'b1);
`else
        lk = 1'b0;
`endif
        if (rst) begin
            m_owner  = -1;
            m_credit = 0;
            m_ptr    = 0;
        end else if (m_owner >= 0 && req[m_owner] && (lk || m_credit > 1)) begin
            if (!lk) m_credit = m_credit - 1;
        end else begin
            cand = -1;
            for (int i = m_ptr; i < N; i++) if (req[i] && cand < 0) cand = i;
            for (int i = 0; i < N; i++)     if (req[i] && cand < 0) cand = i;
            if (cand >= 0) begin
                w        = int'(weight[cand*W +: W]);
                m_owner  = cand;
                m_credit = (w == 0) ? 1 : w;
                m_ptr    = cand + 1;
            end else begin
                m_owner  = -1;
                m_credit = 0;
            end
        end
    end

    task automatic check_model();
        logic [N-1:0] eg;
        logic [N-1:0] em;
        logic [1:0]   eid;
        logic [W-1:0] ec;
        logic         ev;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        for (int i = 0; i < N; i++) em[i] = (i >= m_ptr);
        eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        ec  = 4'(m_credit);
        ev  = (m_owner >= 0);
        n_tests++;
        if (grant !== eg || grant_vld !== ev || grant_id !== eid || credit !== ec || next_mask !== em) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t grant=%b exp=%b vld=%b exp=%b id=%0d exp=%0d credit=%0d exp=%0d mask=%b exp=%b",
                     $time, grant, eg, grant_vld, ev, grant_id, eid, credit, ec, next_mask, em);
        end
    endtask

    // One clock: compare at the falling edge, then leave time for new stimulus.
    task automatic tick();
        @(negedge clk);
        if (chk_en) check_model();
        #1;
    endtask

    task automatic expect_out(input string name, input logic [N-1:0] g, input int c, input logic [N-1:0] m);
        n_tests++;
        if (grant !== g || credit !== 4'(c) || next_mask !== m) begin
            n_fail++;
            $display("FAIL %s grant=%b exp=%b credit=%0d exp=%0d mask=%b exp=%b",
                     name, grant, g, credit, c, next_mask, m);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'b1111;
        weight = {4'd1, 4'd1, 4'd2, 4'd3};
`ifdef WRR_LOCK_EN
        lock   = 1'b0;
`endif
        // Two reset cycles with all requesting.
        tick();
        chk_en = 1;
        tick();
        expect_out("reset", 4'b0000, 0, 4'b1111);

        // Weights w3..w0 = 1,1,2,3 with requesters 0 and 1.
        rst = 1'b0;
        req = 4'b0011;
        tick(); expect_out("wrr_a0", 4'b0001, 3, 4'b1110);
        tick(); expect_out("wrr_a1", 4'b0001, 2, 4'b1110);
        tick(); expect_out("wrr_a2", 4'b0001, 1, 4'b1110);
        tick(); expect_out("wrr_b0", 4'b0010, 2, 4'b1100);
        tick(); expect_out("wrr_b1", 4'b0010, 1, 4'b1100);
        tick(); expect_out("wrr_wrap", 4'b0001, 3, 4'b1110);

        // Owner 3 burst then wrap to requester 0.
        do_reset();
        weight = {4'd2, 4'd1, 4'd1, 4'd1};
        req    = 4'b1000;
        tick(); expect_out("own3_start", 4'b1000, 2, 4'b0000);
        req = 4'b1001;
        tick(); expect_out("own3_hold", 4'b1000, 1, 4'b0000);
        tick(); expect_out("own3_wrap", 4'b0001, 1, 4'b1110);

        // Owner 0 drops request early; handoff to 2 without a gap, then idle keeps mask.
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd5};
        req    = 4'b0101;
        tick(); expect_out("drop_start", 4'b0001, 5, 4'b1110);
        tick(); expect_out("drop_hold", 4'b0001, 4, 4'b1110);
        req = 4'b0100;
        tick(); expect_out("drop_handoff", 4'b0100, 1, 4'b1000);
        req = 4'b0000;
        tick(); expect_out("idle_keep_mask", 4'b0000, 0, 4'b1000);

        // Reset in the middle of owner 1's burst.
        do_reset();
        weight = {4'd1, 4'd1, 4'd4, 4'd1};
        req    = 4'b0010;
        tick(); expect_out("burst1_start", 4'b0010, 4, 4'b1100);
        tick(); expect_out("burst1_c3", 4'b0010, 3, 4'b1100);
        rst = 1'b1;
        tick(); expect_out("midburst_rst", 4'b0000, 0, 4'b1111);
        rst = 1'b0;
        tick(); expect_out("post_rst_grant", 4'b0010, 4, 4'b1100);

        // Sole requester re-wins; weight change mid-burst; weight 0 acts as 1.
        do_reset();
        weight = {4'd1, 4'd2, 4'd0, 4'd1};
        req    = 4'b0100;
        tick(); expect_out("sole_c2", 4'b0100, 2, 4'b1000);
        weight = {4'd1, 4'd3, 4'd0, 4'd1};
        tick(); expect_out("sole_c1", 4'b0100, 1, 4'b1000);
        tick(); expect_out("sole_rewin", 4'b0100, 3, 4'b1000);
        req = 4'b0010;
        tick(); expect_out("w0_as_1", 4'b0010, 1, 4'b1100);
        tick(); expect_out("w0_rewin", 4'b0010, 1, 4'b1100);

`ifdef WRR_LOCK_EN
        // Lock holds owner 2 with credit frozen at 1.
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req    = 4'b0100;
        tick(); expect_out("lock_own2", 4'b0100, 1, 4'b1000);
        req  = 4'b0111;
        lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); expect_out("lock_hold", 4'b0100, 1, 4'b1000);
        end
        lock = 1'b0;
        tick(); expect_out("lock_release", 4'b0001, 1, 4'b1110);
`endif

        // Random traffic checked against the model only.
        for (int k = 0; k < 400; k++) begin
            req = 4'($urandom_range(0, 15));
            if ((k % 16) == 0) weight = 16'($urandom);
            rst = ($urandom_range(0, 39) == 0);
`ifdef WRR_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
